// File: rtl/morse_char_keyer_if.sv
// Handshake bundle between the Morse character counter/ROM side and the keyer.
// master: the side feeding ticks, start and the character stream.
// slave : the keyer itself.
interface morse_char_keyer_if;
  logic       tick;
  logic       start;
  logic [3:0] char_idx;
  logic [5:0] char_code;
  logic       key;
  logic       adv;
  logic       busy;
  logic       done;

  modport master (
    output tick, start, char_idx, char_code,
    input  key, adv, busy, done
  );

  modport slave (
    input  tick, start, char_idx, char_code,
    output key, adv, busy, done
  );
endinterface

// File: rtl/morse_char_keyer.sv
// morse_char_keyer: keys out one Morse character at a time in unit-time ticks,
// pulsing adv to step the upstream character counter after each character.
// Optional build macro MORSE_LOOP_EN: after the last index the message restarts
// from LOAD instead of returning to IDLE (done still pulses each pass).
// All outputs are registered from the next-state decode so they are glitch
// free and clear asynchronously with RST.
module morse_char_keyer #(
  parameter int LAST_IDX   = 10,
  parameter int DASH_UNITS = 3,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input logic          CLK,
  input logic          RST,
  morse_char_keyer_if.slave kif
);

  typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, GAP, ADV} state_t;

  localparam logic [3:0] DASH_T   = 4'(DASH_UNITS);
  localparam logic [3:0] LGAP_T   = 4'(LETTER_GAP);
  localparam logic [3:0] WGAP_T   = 4'(WORD_GAP);
  localparam logic [3:0] LAST_T   = 4'(LAST_IDX);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;     // ticks counted in the current state
  logic [2:0] left_q, left_d;   // elements left, including the current one
  logic [4:0] pat_q, pat_d;     // pattern, current element in bit 4, 1 = dash
  logic [3:0] gap_q, gap_d;     // off-time target for GAP
  logic [3:0] idx_q, idx_d;     // index of the character being sent
  logic       key_q, key_d;
  logic       adv_q, adv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] rom_word;
  logic [3:0] cnt_nxt;
  logic [3:0] unit_tgt;

  // ITU code table: {len[2:0], pattern[4:0]} with the pattern left-aligned.
  // len = 0 marks a space (or any code outside letters/digits).
  function automatic logic [7:0] morse_rom(input logic [5:0] c);
    logic [7:0] w;
    case (c)
      6'd0:  w = 8'b010_01000; // A .-
      6'd1:  w = 8'b100_10000; // B -...
      6'd2:  w = 8'b100_10100; // C -.-.
      6'd3:  w = 8'b011_10000; // D -..
      6'd4:  w = 8'b001_00000; // E .
      6'd5:  w = 8'b100_00100; // F ..-.
      6'd6:  w = 8'b011_11000; // G --.
      6'd7:  w = 8'b100_00000; // H ....
      6'd8:  w = 8'b010_00000; // I ..
      6'd9:  w = 8'b100_01110; // J .---
      6'd10: w = 8'b011_10100; // K -.-
      6'd11: w = 8'b100_01000; // L .-..
      6'd12: w = 8'b010_11000; // M --
      6'd13: w = 8'b010_10000; // N -.
      6'd14: w = 8'b011_11100; // O ---
      6'd15: w = 8'b100_01100; // P .--.
      6'd16: w = 8'b100_11010; // Q --.-
      6'd17: w = 8'b011_01000; // R .-.
      6'd18: w = 8'b011_00000; // S ...
      6'd19: w = 8'b001_10000; // T -
      6'd20: w = 8'b011_00100; // U ..-
      6'd21: w = 8'b100_00010; // V ...-
      6'd22: w = 8'b011_01100; // W .--
      6'd23: w = 8'b100_10010; // X -..-
      6'd24: w = 8'b100_10110; // Y -.--
      6'd25: w = 8'b100_11000; // Z --..
      6'd26: w = 8'b101_11111; // 0 -----
      6'd27: w = 8'b101_01111; // 1 .----
      6'd28: w = 8'b101_00111; // 2 ..---
      6'd29: w = 8'b101_00011; // 3 ...--
      6'd30: w = 8'b101_00001; // 4 ....-
      6'd31: w = 8'b101_00000; // 5 .....
      6'd32: w = 8'b101_10000; // 6 -....
      6'd33: w = 8'b101_11000; // 7 --...
      6'd34: w = 8'b101_11100; // 8 ---..
      6'd35: w = 8'b101_11110; // 9 ----.
      default: w = 8'b000_00000;
    endcase
    return w;
  endfunction

  assign rom_word = morse_rom(kif.char_code);
  assign cnt_nxt  = {1'b0, cnt_q} + 4'd1;
  assign unit_tgt = pat_q[4] ? DASH_T : 4'd1;

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      left_q  <= '0;
      pat_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      key_q   <= 1'b0;
      adv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      pat_q   <= pat_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      adv_q   <= adv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; outputs decode the upcoming state so key rises on MARK entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    pat_d   = pat_q;
    gap_d   = gap_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (kif.start) state_d = LOAD;
      end
      LOAD: begin
        idx_d = kif.char_idx;
        if (rom_word[7:5] != 3'd0) begin
          left_d  = rom_word[7:5];
          pat_d   = rom_word[4:0];
          state_d = MARK;
        end else begin
          gap_d   = WGAP_T;
          state_d = GAP;
        end
      end
      MARK: begin
        if (kif.tick) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_nxt == unit_tgt) begin
            if (left_q > 3'd1) begin
              left_d  = left_q - 3'd1;
              pat_d   = {pat_q[3:0], 1'b0};
              state_d = SPACE;
            end else begin
              gap_d   = LGAP_T;
              state_d = GAP;
            end
          end
        end
      end
      SPACE: begin
        if (kif.tick) state_d = MARK;
      end
      GAP: begin
        if (kif.tick) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_nxt == gap_q) state_d = ADV;
        end
      end
      ADV: begin
        if (idx_q == LAST_T) begin
`ifdef MORSE_LOOP_EN
          state_d = LOAD;
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry starts its tick count afresh.
    if (state_d != state_q) cnt_d = '0;

    key_d  = (state_d == MARK);
    busy_d = (state_d != IDLE);
    adv_d  = (state_d == ADV);
    done_d = adv_d && (idx_d == LAST_T);
  end

  assign kif.key  = key_q;
  assign kif.adv  = adv_q;
  assign kif.busy = busy_q;
  assign kif.done = done_q;

endmodule

// File: tb/tb_morse_char_keyer.sv
// Bench for morse_char_keyer: a segment-queue model of the key waveform,
// an emulated upstream counter, directed cases plus randomized messages.
module tb_morse_char_keyer;
  localparam int LAST = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  morse_char_keyer_if kif();
  morse_char_keyer dut (.CLK(CLK), .RST(RST), .kif(kif));

  // Upstream counter emulation: index advances on every adv pulse, wraps after LAST.
  logic [5:0] msg [0:10];
  int idx_base = 0;
  int adv_pulses = 0, done_pulses = 0, on_ticks = 0, busy_cycles = 0;
  logic [3:0] env_idx;
  assign env_idx       = 4'((idx_base + adv_pulses) % 11);
  assign kif.char_idx  = env_idx;
  assign kif.char_code = msg[env_idx];

  always @(posedge CLK) begin
    if (kif.adv)              adv_pulses  <= adv_pulses + 1;
    if (kif.done)             done_pulses <= done_pulses + 1;
    if (kif.tick && kif.key)  on_ticks    <= on_ticks + 1;
    if (kif.busy)             busy_cycles <= busy_cycles + 1;
  end

  // Tick source: period N (1 = every cycle) or random density 1/4 when 0.
  int tick_period = 10;
  int cyc = 0;
  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (tick_period > 0) kif.tick <= ((cyc % tick_period) == 0);
    else                 kif.tick <= ($urandom_range(0, 3) == 0);
  end

  // ---------------- reference model ----------------
  string tbl [0:35] = '{".-","-...","-.-.","-..",".","..-.","--.","....","..",".---",
                        "-.-",".-..","--","-.","---",".--.","--.-",".-.","...","-",
                        "..-","...-",".--","-..-","-.--","--..","-----",".----","..---",
                        "...--","....-",".....","-....","--...","---..","----."};

  typedef struct { bit lvl; int n; } seg_t;
  seg_t segs[$];
  bit m_load = 0, m_adv = 0;
  int m_idx = 0;

  function automatic int exp_on_ticks(input int c);
    int s;
    string p;
    s = 0;
    if (c < 36) begin
      p = tbl[c];
      for (int i = 0; i < p.len(); i++) s += (p.getc(i) == "-") ? 3 : 1;
    end
    return s;
  endfunction

  // Expand one character into on/off segments measured in ticks.
  function automatic void build(input int c);
    string p;
    if (c < 36) begin
      p = tbl[c];
      for (int i = 0; i < p.len(); i++) begin
        segs.push_back(seg_t'{lvl: 1'b1, n: (p.getc(i) == "-") ? 3 : 1});
        if (i < p.len() - 1) segs.push_back(seg_t'{lvl: 1'b0, n: 1});
      end
      segs.push_back(seg_t'{lvl: 1'b0, n: 3});
    end else begin
      segs.push_back(seg_t'{lvl: 1'b0, n: 7});
    end
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      segs.delete();
      m_load = 0;
      m_adv  = 0;
      m_idx  = 0;
    end else if (m_load) begin
      m_load = 0;
      m_idx  = int'(kif.char_idx);
      build(int'(kif.char_code));
    end else if (m_adv) begin
      m_adv = 0;
      if (m_idx != LAST) m_load = 1;
`ifdef MORSE_LOOP_EN
      else m_load = 1;
`endif
    end else if (segs.size() > 0) begin
      if (kif.tick) begin
        segs[0].n = segs[0].n - 1;
        if (segs[0].n == 0) begin
          void'(segs.pop_front());
          if (segs.size() == 0) m_adv = 1;
        end
      end
    end else if (kif.start) begin
      m_load = 1;
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0;
  int req_seq = 0, seen_seq = 0;
  string req_name;
  int req_act, req_exp;

  task automatic cmp(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // Single compare process: per-cycle model checks plus queued literal checks.
  always @(negedge CLK) begin
    cmp("key",  int'(kif.key),  int'(segs.size() > 0 && segs[0].lvl));
    cmp("adv",  int'(kif.adv),  int'(m_adv));
    cmp("busy", int'(kif.busy), int'(m_load || m_adv || segs.size() > 0));
    cmp("done", int'(kif.done), int'(m_adv && m_idx == LAST));
    if (req_seq != seen_seq) begin
      seen_seq = req_seq;
      cmp(req_name, req_act, req_exp);
    end
  end

  task automatic lit(input string n, input int a, input int e);
    req_name = n;
    req_act  = a;
    req_exp  = e;
    req_seq++;
    @(negedge CLK);
    #1;
  endtask

  task automatic set_idx(input int k);
    idx_base = (k - (adv_pulses % 11) + 11) % 11;
  endtask

  task automatic start_msg();
    @(negedge CLK);
    kif.start = 1'b1;
    @(negedge CLK);
    kif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit got;
    got = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (kif.done) begin
        got = 1;
        break;
      end
      if (rnd) kif.start = ($urandom_range(0, 7) == 0);
    end
    kif.start = 1'b0;
    lit("done_within_budget", int'(got), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ot, ap, dp, bc, eo;
    bit got;
    logic kpre, kpost;
    kif.start = 1'b0;
    for (int i = 0; i <= LAST; i++) msg[i] = 6'd4;

    // 1: reset held with start high and ticks running
    tick_period = 2;
    kif.start = 1'b1;
    repeat (3) @(negedge CLK);
    kif.start = 1'b0;
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    lit("idle_no_adv", adv_pulses, 0);

    // 2: single 'E' at the last index, tick every 10 cycles
    tick_period = 10;
    set_idx(10); msg[10] = 6'd4;
    ot = on_ticks; ap = adv_pulses; dp = done_pulses;
    start_msg();
    wait_done(500, 0);
    repeat (4) @(negedge CLK);
    lit("E_on_ticks", on_ticks - ot, 1);
    lit("E_adv", adv_pulses - ap, 1);
    lit("E_done", done_pulses - dp, 1);

    // 2b: 'E' with a tick every cycle: LOAD + 1 mark + 3 gap + ADV
    tick_period = 1;
    set_idx(10);
    bc = busy_cycles;
    start_msg();
    wait_done(100, 0);
    repeat (3) @(negedge CLK);
    lit("E_busy_cycles", busy_cycles - bc, 6);

    // 3: 'A' at idx 9 then 'T' at idx 10
    tick_period = 10;
    msg[9] = 6'd0; msg[10] = 6'd19;
    set_idx(9);
    ot = on_ticks; ap = adv_pulses; dp = done_pulses;
    start_msg();
    wait_done(1000, 0);
    repeat (4) @(negedge CLK);
    lit("AT_on_ticks", on_ticks - ot, 7);
    lit("AT_adv", adv_pulses - ap, 2);
    lit("AT_done", done_pulses - dp, 1);

    // 4: space and an invalid code both give a 7-tick word gap
    msg[10] = 6'd36;
    set_idx(10);
    ot = on_ticks; ap = adv_pulses;
    start_msg();
    wait_done(500, 0);
    repeat (4) @(negedge CLK);
    lit("space_on_ticks", on_ticks - ot, 0);
    lit("space_adv", adv_pulses - ap, 1);
    tick_period = 1;
    msg[10] = 6'd50;
    set_idx(10);
    bc = busy_cycles;
    start_msg();
    wait_done(100, 0);
    repeat (3) @(negedge CLK);
    lit("invalid_busy_cycles", busy_cycles - bc, 9);

    // 5: '0', reset asynchronously after the 2nd tick of the 3rd dash
    tick_period = 10;
    msg[10] = 6'd26;
    set_idx(10);
    ot = on_ticks; ap = adv_pulses;
    start_msg();
    got = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge CLK);
      if (on_ticks - ot >= 8) begin got = 1; break; end
    end
    lit("reached_third_dash", int'(got), 1);
    #2;
    kpre = kif.key;
    RST = 1'b1;
    #1;
    kpost = kif.key;
    lit("key_before_rst", int'(kpre), 1);
    lit("key_async_drop", int'(kpost), 0);
    lit("rst_no_adv", adv_pulses - ap, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    set_idx(10);
    ot = on_ticks;
    start_msg();
    wait_done(2000, 0);
    repeat (3) @(negedge CLK);
    lit("zero_restart_on_ticks", on_ticks - ot, 15);

    // Randomized messages with random start noise while busy
    for (int r = 0; r < 4; r++) begin
      eo = 0;
      for (int i = 0; i <= LAST; i++) begin
        msg[i] = 6'($urandom_range(0, 63));
        eo += exp_on_ticks(int'(msg[i]));
      end
      tick_period = $urandom_range(0, 3);
      set_idx(0);
      ot = on_ticks; ap = adv_pulses; dp = done_pulses;
      start_msg();
      wait_done(6000, 1);
      repeat (4) @(negedge CLK);
      lit("rand_on_ticks", on_ticks - ot, eo);
      lit("rand_adv", adv_pulses - ap, 11);
      lit("rand_done", done_pulses - dp, 1);
    end

`ifdef MORSE_LOOP_EN
    // 6: looping message of 'E', start noise ignored, two full passes
    for (int i = 0; i <= LAST; i++) msg[i] = 6'd4;
    tick_period = 2;
    set_idx(0);
    ap = adv_pulses; dp = done_pulses;
    start_msg();
    wait_done(3000, 1);
    wait_done(3000, 1);
    lit("loop_done", done_pulses - dp, 2);
    lit("loop_adv", adv_pulses - ap, 22);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_char_keyer.md
Name: morse_char_keyer

Overview:
- Downstream neighbour of the 11-state character counter (count 0..10) in the Morse transmitter.
- Consumes the counter's 4-bit index and the character code fetched at that index, and keys out the Morse pattern in unit-time ticks.
- Pulses the counter's EN for exactly one cycle to advance to the next character.
- Stops after the last index, or loops when the optional feature is compiled in.

Parameters:
- LAST_IDX, 10: counter index of the final character in the message.
- DASH_UNITS, 3: dash length in ticks.
- LETTER_GAP, 3: total off-time after a character's last element, in ticks.
- WORD_GAP, 7: total off-time for a space character, in ticks.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle pulse per Morse unit time.
- start  in  1  begin transmission; sampled only in IDLE.
- char_idx  in  4  current counter index (0..10).
- char_code  in  6  character at char_idx:
  - 0..25 = A..Z
  - 26..35 = digits 0..9
  - 36 = space
  - 37..63 = treated as space
- key  out  1  Morse keying output; 1 = carrier on.
- adv  out  1  one-cycle pulse; drives the counter EN.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the message is finished.

Behaviour:
- Reset (asynchronous): state = IDLE; key, adv, busy and done = 0; all internal counters = 0. Reset mid-element drops key in the same instant.
- States: IDLE, LOAD, MARK, SPACE, GAP, ADV.
- IDLE:
  - start=1 -> LOAD on the next edge.
  - start in any other state is ignored.
- LOAD (1 cycle):
  - Latch char_idx and char_code.
  - Internal ROM gives len (1..5) and pattern, MSB-first, with 1 = dash.
  - Letters and digits use standard ITU codes.
  - Letter or digit -> MARK with element index 0.
  - Space or invalid code -> GAP with target WORD_GAP.
- MARK:
  - key=1 from the first MARK cycle.
  - Unit counter increments on each tick.
  - On the tick reaching 1 (dot) or DASH_UNITS (dash): if more elements remain -> SPACE; otherwise -> GAP with target LETTER_GAP.
- SPACE: key=0 for exactly 1 tick -> MARK with the next element.
- GAP: key=0 until target ticks are counted -> ADV.
- ADV (1 cycle):
  - adv=1.
  - If latched idx == LAST_IDX: done=1 -> IDLE.
  - Otherwise -> LOAD. The counter updates on this edge, so LOAD sees the new index.
- Tick counting:
  - key changes only on the clock edge following a counted tick, except on entry to MARK from LOAD or SPACE.
  - A tick arriving in the LOAD or ADV cycle is ignored.
- Unit counter:
  - 3 bits.
  - Cleared on every state entry.
  - Never wraps, because the maximum target is 7.
- busy is high in every non-IDLE state, including the ADV cycle. It drops the cycle after done.
- adv and done are never high for more than one cycle. done implies adv in the same cycle.

Optional Feature:
- Macro: MORSE_LOOP_EN.
- Defined:
  - In ADV with idx == LAST_IDX, done still pulses but the next state is LOAD, not IDLE.
  - The counter wraps to 0 and transmission repeats indefinitely until RST.
- Undefined: stops in IDLE after LAST_IDX as described above.

Test Plan:
1. RST=1 for 3 cycles with start=1 and tick running -> key=adv=busy=done=0 throughout; state stays IDLE after release until start is pulsed.
2. char_idx=10, char_code=4 ('E'), start pulse, tick every 10 cycles -> key high for exactly 1 tick, then low for 3 ticks; then adv=1 and done=1 in the same single cycle; busy=0 on the next cycle.
3. char_idx=9 with 'A' (0), then idx 10 with 'T' (19) -> key pattern in ticks: 1 on, 1 off, 3 on, 3 off, adv; then 3 on, 3 off, adv+done; exactly two adv pulses.
4. char_code=36 (space) at idx 10, and separately char_code=50 -> key stays 0 for 7 ticks, then adv+done.
5. '0' (26) at idx 10; assert RST after the 2nd tick of the 3rd dash -> key falls without waiting for a clock edge; no adv; a later start restarts from LOAD.
6. MORSE_LOOP_EN defined; message 'E' at every index; start pulse -> done pulses after idx 10, then LOAD resamples idx 0; key continues with no IDLE cycle; start pulses during the run have no effect.
